// File: rtl/serial_adder_if.sv
// Request/response bundle for serial_adder: operands and mode in, status and result out.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder slice, LSB-first, WIDTH cycles per operation.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  serial_adder_if.slave      bus
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             bit_s;
  logic             carry_n;
  logic [WIDTH-1:0] res_shift;
  logic             last_bit;

  always_comb begin
    bit_s     = a_q[0] ^ b_q[0] ^ carry_q;
    carry_n   = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
    // Shift-then-insert form keeps WIDTH=1 legal (no [WIDTH-1:1] slice).
    res_shift = res_q >> 1;
    res_shift[WIDTH-1] = bit_s;
    last_bit  = (cnt_q == CW'(WIDTH - 1));
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b ^ {WIDTH{bus.sub}};
          carry_d = bus.sub ? 1'b1 : bus.cin;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = carry_n;
        res_d   = res_shift;
        cnt_d   = cnt_q + CW'(1);
        if (last_bit) begin
          // Overflow uses the carry into and out of the MSB slice on this final bit.
          sum_d   = res_shift;
          cout_d  = carry_n;
          ovf_d   = carry_q ^ carry_n;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy = (state_q == ST_RUN);
  assign bus.done = (state_q == ST_DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8) with hand-computed results.
module tb_serial_adder;
  localparam int WIDTH = 8;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  logic [WIDTH-1:0] last_sum;

  serial_adder_if #(.WIDTH(WIDTH)) bus ();

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // One operation; optionally pulses a stray start mid-run and verifies it is ignored.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic sub, input logic cin,
                        input logic [7:0] exp_sum, input logic exp_cout, input logic exp_ovf,
                        input bit stray);
    int busy_cnt;
    int done_at;
    int extra_done;
    @(negedge clk);
    bus.start = 1'b1; bus.a = a; bus.b = b; bus.sub = sub; bus.cin = cin;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.a = ~a; bus.b = ~b; bus.sub = ~sub; bus.cin = ~cin;
    busy_cnt = 0;
    if (bus.busy) busy_cnt++;
    check({tag, ".hold_sum"}, 64'(bus.sum), 64'(last_sum));
    done_at = 0;
    for (int i = 1; i <= 20; i++) begin
      if (stray && i == 2) begin bus.start = 1'b1; bus.a = 8'h11; bus.b = 8'h22; bus.sub = 1'b0; end
      if (stray && i == 3) bus.start = 1'b0;
      @(posedge clk); #1;
      if (bus.done) begin done_at = i; break; end
      if (bus.busy) busy_cnt++;
      if (bus.busy) check({tag, ".run_sum"}, 64'(bus.sum), 64'(last_sum));
    end
    check({tag, ".latency"}, 64'(done_at), 64'(WIDTH));
    check({tag, ".busy_cycles"}, 64'(busy_cnt), 64'(WIDTH));
    check({tag, ".sum"},  64'(bus.sum),  64'(exp_sum));
    check({tag, ".cout"}, 64'(bus.cout), 64'(exp_cout));
    check({tag, ".ovf"},  64'(bus.ovf),  64'(exp_ovf));
    last_sum = exp_sum;
    @(posedge clk); #1;
    check({tag, ".done_clear"}, 64'({bus.done, bus.busy}), 64'(0));
    if (stray) begin
      extra_done = 0;
      for (int i = 0; i < 12; i++) begin
        @(posedge clk); #1;
        if (bus.done || bus.busy) extra_done++;
      end
      check({tag, ".no_second_op"}, 64'(extra_done), 64'(0));
      check({tag, ".sum_kept"}, 64'(bus.sum), 64'(exp_sum));
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    last_sum = '0;
    rst = 1'b1;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.sub = 1'b0; bus.cin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.busy_done", 64'({bus.busy, bus.done}), 64'(0));
    check("reset.results", 64'({bus.sum, bus.cout, bus.ovf}), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    run_op("add_0f_01",  8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0);
    run_op("add_ff_01",  8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    run_op("add_ff_00c", 8'hFF, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    run_op("add_7f_01",  8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
    run_op("sub_80_01",  8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b0);
    run_op("sub_05_07",  8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);
    run_op("sub_07_05",  8'h07, 8'h05, 1'b1, 1'b0, 8'h02, 1'b1, 1'b0, 1'b0);
    run_op("add_3c_42c", 8'h3C, 8'h42, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b0, 1'b0);
    run_op("stray_start", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 1'b1);

    // Abort 0xAA+0x55 mid-run; previous result 0x10 must vanish without a clock edge.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'hAA; bus.b = 8'h55; bus.sub = 1'b0; bus.cin = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort.busy_before", 64'(bus.busy), 64'(1));
    rst = 1'b1;
    #1;
    check("abort.busy_done", 64'({bus.busy, bus.done}), 64'(0));
    check("abort.results", 64'({bus.sum, bus.cout, bus.ovf}), 64'(0));
    bus.start = 1'b1; bus.a = 8'h33; bus.b = 8'h33;
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort.start_in_rst", 64'({bus.busy, bus.done}), 64'(0));
    last_sum = '0;
    run_op("post_rst_01_01", 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
